// File: rtl/fabric_config_pkg.sv
// fabric_config_pkg: states, word width and default timing for the configuration sequencer
package fabric_config_pkg;
    localparam int CFG_WORD_W       = 32;
    localparam int CNT_W            = 16;
    localparam int DEF_ADDR_W       = 12;
    localparam int DEF_SETUP_CYCLES = 2;
    localparam int DEF_GAP_CYCLES   = 2;
    localparam int DEF_POST_CYCLES  = 100;
    localparam int DEF_RST_CYCLES   = 5;
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT, S_SETUP, S_STROBE, S_GAP, S_POST, S_URST, S_RUN
    } state_t;
endpackage

// File: rtl/fabric_config_sequencer.sv
// fabric_config_sequencer: streams a stored bitstream into the self-write port, then releases the user design
module fabric_config_sequencer
    import fabric_config_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int POST_CYCLES  = DEF_POST_CYCLES,
    parameter int RST_CYCLES   = DEF_RST_CYCLES
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_W:0]       word_count,
    output logic                  mem_rd,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [CFG_WORD_W-1:0] mem_rdata,
    input  logic                  ComActive,
    output logic [CFG_WORD_W-1:0] SelfWriteData,
    output logic                  SelfWriteStrobe,
    output logic                  user_rst,
    output logic                  user_en,
    output logic                  busy,
    output logic                  done
);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 2);
    localparam logic [CNT_W-1:0] POST_LD  = CNT_W'(POST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [ADDR_W:0]         idx_q, idx_d, count_q, count_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CFG_WORD_W-1:0]   data_q, data_d;
    logic                    go, last_word, gap_end;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = count_q;
        cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        data_d    = (state_q == S_WAIT) ? mem_rdata : data_q;
        go        = start && (state_q == S_IDLE || state_q == S_RUN);
        last_word = (idx_q + (ADDR_W+1)'(1)) == count_q;
        // The gap is counted from the strobe cycle, so a one-cycle gap skips the GAP state.
        gap_end   = (state_q == S_GAP && cnt_q == '0) || (state_q == S_STROBE && GAP_CYCLES == 1);
        if (go) begin
            count_d = word_count;
            idx_d   = '0;
            state_d = (word_count == '0) ? S_POST : S_FETCH;
            cnt_d   = POST_LD;
        end else if (gap_end) begin
            // The index stops on the last word so mem_addr never wraps to 0.
            idx_d   = last_word ? idx_q : idx_q + (ADDR_W+1)'(1);
            state_d = last_word ? S_POST : S_FETCH;
            cnt_d   = POST_LD;
        end else begin
            case (state_q)
                S_FETCH:  state_d = ComActive ? S_FETCH : S_WAIT;
                S_WAIT:   begin state_d = S_SETUP; cnt_d = SETUP_LD; end
                S_SETUP:  state_d = (cnt_q == '0) ? S_STROBE : S_SETUP;
                S_STROBE: begin state_d = S_GAP; cnt_d = GAP_LD; end
                S_POST:   if (cnt_q == '0) begin state_d = S_URST; cnt_d = RST_LD; end
                S_URST:   state_d = (cnt_q == '0) ? S_RUN : S_URST;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            count_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign mem_rd          = (state_q == S_FETCH) && !ComActive;
    assign mem_addr        = idx_q[ADDR_W-1:0];
    assign SelfWriteData   = data_q;
    assign SelfWriteStrobe = (state_q == S_STROBE);
    assign user_rst        = (state_q == S_URST);
    assign user_en         = (state_q == S_RUN);
    assign done            = (state_q == S_RUN);
    assign busy            = (state_q != S_IDLE) && (state_q != S_RUN);
endmodule

// File: tb/tb_fabric_config_sequencer.sv
// tb_fabric_config_sequencer: table, hand-written and randomized loads checked against a timing model
module tb_fabric_config_sequencer;
    localparam int SETUP = 2;
    localparam int GAP   = 2;
    localparam int POST  = 100;
    localparam int RST   = 5;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [12:0] word_count = '0;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        ComActive = 1'b0;
    logic [31:0] SelfWriteData;
    logic        SelfWriteStrobe, user_rst, user_en, busy, done;

    fabric_config_sequencer dut (
        .CLK(CLK), .resetn(resetn), .start(start), .word_count(word_count),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .ComActive(ComActive), .SelfWriteData(SelfWriteData),
        .SelfWriteStrobe(SelfWriteStrobe), .user_rst(user_rst), .user_en(user_en),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    int tests = 0, fails = 0;
    int cyc = 0;
    int ca_lo = 0, ca_hi = 0;
    logic [31:0] mem [4096];
    int st_cyc[$], rd_cyc[$], e_st[$], e_rd[$];
    logic [31:0] st_dat[$];
    logic [11:0] rd_adr[$];
    int done_cyc = -1, rst_first = -1, urst_cnt = 0;
    int e_done, e_rst_first;

    typedef struct {
        int wc, lo_off, len;
        bit inj;
        int n, s1, s2, dn;
    } vec_t;
    vec_t tbl[6];

    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) if (mem_rd) mem_rdata <= mem[mem_addr];

    initial forever begin
        @(posedge CLK); #1;
        ComActive = (cyc >= ca_lo) && (cyc < ca_hi);
    end

    initial forever begin
        @(negedge CLK);
        if (SelfWriteStrobe) begin st_cyc.push_back(cyc); st_dat.push_back(SelfWriteData); end
        if (mem_rd) begin rd_cyc.push_back(cyc); rd_adr.push_back(mem_addr); end
        if (user_rst) begin if (urst_cnt == 0) rst_first = cyc; urst_cnt++; end
        if (done && done_cyc < 0) done_cyc = cyc;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each word waits for ComActive to be low, then takes fetch+wait+setup to its strobe; the next fetch
    // slot is GAP cycles after that strobe.
    function automatic void model(input int s, input int wc, input int lo, input int hi);
        int t = s;
        e_st.delete(); e_rd.delete();
        for (int i = 0; i < wc; i++) begin
            while (t >= lo && t < hi) t++;
            e_rd.push_back(t);
            t += 2 + SETUP;
            e_st.push_back(t);
            t += GAP;
        end
        e_rst_first = t + POST;
        e_done      = t + POST + RST;
    endfunction

    task automatic run_load(input int wc, input int lo_off, input int len, input bit inject, output int s);
        int budget, mism;
        @(posedge CLK); #1;
        s = cyc + 1;
        ca_lo = s + lo_off;
        ca_hi = s + lo_off + len;
        model(s, wc, ca_lo, ca_hi);
        start = 1'b1;
        word_count = 13'(wc);
        @(posedge CLK); #1;
        start = 1'b0;
        st_cyc.delete(); st_dat.delete(); rd_cyc.delete(); rd_adr.delete();
        done_cyc = -1; rst_first = -1; urst_cnt = 0;
        @(negedge CLK);
        chk("user_en_drop", user_en, 0);
        chk("busy_after_start", busy, 1);
        budget = e_done - s + 40;
        for (int c = 0; c < budget && done_cyc < 0; c++) begin
            @(posedge CLK); #1;
            start = inject && (cyc < e_done) && ($urandom_range(0, 5) == 0);
        end
        start = 1'b0;
        chk("done_seen", done_cyc >= 0, 1);
        chk("strobe_count", st_cyc.size(), e_st.size());
        chk("rd_count", rd_cyc.size(), e_rd.size());
        mism = 0;
        for (int i = 0; i < st_cyc.size() && i < e_st.size(); i++)
            if (st_cyc[i] != e_st[i] || st_dat[i] !== mem[i]) mism++;
        chk("strobe_time_data", mism, 0);
        mism = 0;
        for (int i = 0; i < rd_cyc.size() && i < e_rd.size(); i++)
            if (rd_cyc[i] != e_rd[i] || int'(rd_adr[i]) != i) mism++;
        chk("rd_time_addr", mism, 0);
        chk("done_cycle", done_cyc, e_done);
        chk("urst_first", rst_first, e_rst_first);
        chk("urst_len", urst_cnt, RST);
        if (wc > 0) chk("data_hold", SelfWriteData, mem[wc-1]);
    endtask

    initial begin
        int s, zeros;
        tbl[0] = '{wc: 3, lo_off: 0, len: 0,  inj: 1, n: 3, s1: 5, s2: 11, dn: 124};
        tbl[1] = '{wc: 3, lo_off: 5, len: 20, inj: 0, n: 3, s1: 5, s2: 30, dn: 143};
        tbl[2] = '{wc: 1, lo_off: 0, len: 0,  inj: 0, n: 1, s1: 5, s2: 0,  dn: 112};
        tbl[3] = '{wc: 0, lo_off: 0, len: 0,  inj: 1, n: 0, s1: 0, s2: 0,  dn: 106};
        tbl[4] = '{wc: 2, lo_off: 5, len: 5,  inj: 0, n: 2, s1: 5, s2: 15, dn: 122};
        tbl[5] = '{wc: 2, lo_off: 5, len: 1,  inj: 0, n: 2, s1: 5, s2: 11, dn: 118};
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[0] = 32'hA0000001; mem[1] = 32'hB0000002; mem[2] = 32'hC0000003;

        #3;
        chk("rst_data", SelfWriteData, 0);
        chk("rst_strobe", SelfWriteStrobe, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_user_rst", user_rst, 0);
        chk("rst_user_en", user_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge CLK);
        #3 resetn = 1'b1;

        foreach (tbl[k]) begin
            run_load(tbl[k].wc, tbl[k].lo_off, tbl[k].len, tbl[k].inj, s);
            chk("tbl_nstrobe", st_cyc.size(), tbl[k].n);
            if (st_cyc.size() > 0) chk("tbl_s1", st_cyc[0] - s + 1, tbl[k].s1);
            if (st_cyc.size() > 1) chk("tbl_s2", st_cyc[1] - s + 1, tbl[k].s2);
            chk("tbl_done", done_cyc - s + 1, tbl[k].dn);
        end

        @(posedge CLK); #1;
        start = 1'b1; word_count = 13'd3;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        chk("midload_word1", SelfWriteData, mem[1]);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_data", SelfWriteData, 0);
        chk("midrst_strobe", SelfWriteStrobe, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done_en", {done, user_en, user_rst, mem_rd}, 0);
        @(posedge CLK); #3 resetn = 1'b1;
        run_load(2, 0, 0, 0, s);
        chk("restart_addr0", rd_adr.size() > 0 && rd_adr[0] == 12'h000, 1);

        for (int r = 0; r < 6; r++)
            run_load($urandom_range(1, 10), $urandom_range(0, 40), $urandom_range(0, 30), 1, s);

        run_load(4096, 0, 0, 0, s);
        if (rd_adr.size() > 0) chk("full_last_addr", rd_adr[rd_adr.size()-1], 12'hFFF);
        zeros = 0;
        foreach (rd_adr[i]) if (rd_adr[i] == 12'h000) zeros++;
        chk("full_no_wrap", zeros, 1);
        chk("full_final_addr", mem_addr, 12'hFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
